// File: rtl/ip_checksum_ttl_update.sv
// rtl/ip_checksum_ttl_update.sv - IPv4 header checksum verify, TTL decrement and expiry redirect stage
module ip_checksum_ttl_update #(
    parameter int C_M_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_M_AXIS_TUSER_WIDTH = 128,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int SRC_PORT_POS         = 16,
    parameter int DST_PORT_POS         = 24
) (
    input  logic                              AXI_ACLK,
    input  logic                              AXI_RESETN,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    S_AXIS_TDATA,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  S_AXIS_TSTRB,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   S_AXIS_TUSER,
    input  logic                              S_AXIS_TVALID,
    output logic                              S_AXIS_TREADY,
    input  logic                              S_AXIS_TLAST,
    output logic [C_M_AXIS_DATA_WIDTH-1:0]    M_AXIS_TDATA,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  M_AXIS_TSTRB,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]   M_AXIS_TUSER,
    output logic                              M_AXIS_TVALID,
    input  logic                              M_AXIS_TREADY,
    output logic                              M_AXIS_TLAST,
    output logic [31:0]                       fwd_count,
    output logic [31:0]                       bad_csum_count,
    output logic [31:0]                       ttl_exp_count
);

    typedef enum logic [2:0] {IDLE, HDR_WAIT, HDR_EMIT, PASS, DROP} state_t;

    state_t state, state_nxt;
    logic   ready_en;

    logic [C_S_AXIS_DATA_WIDTH-1:0]   b0_data, b1_data, hdr0_data;
    logic [C_S_AXIS_DATA_WIDTH/8-1:0] b0_strb, b1_strb;
    logic [C_S_AXIS_TUSER_WIDTH-1:0]  b0_user, b1_user, hdr0_user;
    logic                             b1_last;

    logic        m_free, candidate, hdr_good, ttl_live;
    logic [19:0] csum_acc, csum_fold1;
    logic [15:0] csum_fold2, csum_new;
    logic [16:0] csum_inc;
    logic [7:0]  ttl;

    logic s_ready, cap_b0, cap_b1, load_in, load_hdr0, load_hdr1;
    logic inc_fwd, inc_bad, inc_exp;

    assign m_free        = !M_AXIS_TVALID || M_AXIS_TREADY;
    assign S_AXIS_TREADY = s_ready;
    assign candidate     = (S_AXIS_TDATA[159:144] == 16'h0800) &&
                           (S_AXIS_TDATA[143:136] == 8'h45) && !S_AXIS_TLAST;
    assign ttl           = b0_data[79:72];
    assign ttl_live      = ttl >= 8'd2;

    // One's complement sum of the nine captured words plus the last word arriving on beat 1
    always_comb begin
        csum_acc = {4'd0, S_AXIS_TDATA[255:240]};
        for (int i = 0; i < 9; i++) begin
            csum_acc = csum_acc + {4'd0, b0_data[143-16*i -: 16]};
        end
        csum_fold1 = {4'd0, csum_acc[15:0]} + {16'd0, csum_acc[19:16]};
        csum_fold2 = csum_fold1[15:0] + {12'd0, csum_fold1[19:16]};
        hdr_good   = csum_fold2 == 16'hFFFF;
    end

    // Rewritten beat 0: TTL-1 with incremental checksum patch, or CPU redirect on expiry
    always_comb begin
        hdr0_data = b0_data;
        hdr0_user = b0_user;
        csum_inc  = {1'b0, b0_data[63:48]} + 17'h00100;
        csum_new  = csum_inc[15:0] + {15'd0, csum_inc[16]};
        if (ttl_live) begin
            hdr0_data[79:72] = ttl - 8'd1;
            hdr0_data[63:48] = csum_new;
        end else begin
            hdr0_user[DST_PORT_POS +: 8] = {b0_user[SRC_PORT_POS +: 7], 1'b0};
        end
    end

    // Next-state, input ready and datapath load selects
    always_comb begin
        state_nxt = state;
        s_ready   = 1'b0;
        cap_b0    = 1'b0;
        cap_b1    = 1'b0;
        load_in   = 1'b0;
        load_hdr0 = 1'b0;
        load_hdr1 = 1'b0;
        inc_fwd   = 1'b0;
        inc_bad   = 1'b0;
        inc_exp   = 1'b0;
        case (state)
            IDLE: begin
                s_ready = ready_en && m_free;
                if (S_AXIS_TVALID && s_ready) begin
                    if (candidate) begin
                        cap_b0    = 1'b1;
                        state_nxt = HDR_WAIT;
                    end else begin
                        load_in = 1'b1;
                        if (!S_AXIS_TLAST) state_nxt = PASS;
                    end
                end
            end
            HDR_WAIT: begin
                s_ready = m_free;
                if (S_AXIS_TVALID && s_ready) begin
                    if (hdr_good) begin
                        cap_b1    = 1'b1;
                        load_hdr0 = 1'b1;
                        inc_fwd   = ttl_live;
                        inc_exp   = !ttl_live;
                        state_nxt = HDR_EMIT;
                    end else begin
                        inc_bad   = 1'b1;
                        state_nxt = S_AXIS_TLAST ? IDLE : DROP;
                    end
                end
            end
            HDR_EMIT: begin
                if (m_free) begin
                    load_hdr1 = 1'b1;
                    state_nxt = b1_last ? IDLE : PASS;
                end
            end
            PASS: begin
                s_ready = m_free;
                if (S_AXIS_TVALID && s_ready) begin
                    load_in = 1'b1;
                    if (S_AXIS_TLAST) state_nxt = IDLE;
                end
            end
            DROP: begin
                s_ready = 1'b1;
                if (S_AXIS_TVALID && S_AXIS_TLAST) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register and post-reset input enable
    always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
        if (!AXI_RESETN) begin
            state    <= IDLE;
            ready_en <= 1'b0;
        end else begin
            state    <= state_nxt;
            ready_en <= 1'b1;
        end
    end

    // Header beat capture while the checksum decision is pending
    always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
        if (!AXI_RESETN) begin
            b0_data <= '0;
            b0_strb <= '0;
            b0_user <= '0;
            b1_data <= '0;
            b1_strb <= '0;
            b1_user <= '0;
            b1_last <= 1'b0;
        end else begin
            if (cap_b0) begin
                b0_data <= S_AXIS_TDATA;
                b0_strb <= S_AXIS_TSTRB;
                b0_user <= S_AXIS_TUSER;
            end
            if (cap_b1) begin
                b1_data <= S_AXIS_TDATA;
                b1_strb <= S_AXIS_TSTRB;
                b1_user <= S_AXIS_TUSER;
                b1_last <= S_AXIS_TLAST;
            end
        end
    end

    // Output register: loads only when empty or being drained, otherwise holds stable
    always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
        if (!AXI_RESETN) begin
            M_AXIS_TDATA  <= '0;
            M_AXIS_TSTRB  <= '0;
            M_AXIS_TUSER  <= '0;
            M_AXIS_TLAST  <= 1'b0;
            M_AXIS_TVALID <= 1'b0;
        end else if (load_in) begin
            M_AXIS_TDATA  <= S_AXIS_TDATA;
            M_AXIS_TSTRB  <= S_AXIS_TSTRB;
            M_AXIS_TUSER  <= S_AXIS_TUSER;
            M_AXIS_TLAST  <= S_AXIS_TLAST;
            M_AXIS_TVALID <= 1'b1;
        end else if (load_hdr0) begin
            M_AXIS_TDATA  <= hdr0_data;
            M_AXIS_TSTRB  <= b0_strb;
            M_AXIS_TUSER  <= hdr0_user;
            M_AXIS_TLAST  <= 1'b0;
            M_AXIS_TVALID <= 1'b1;
        end else if (load_hdr1) begin
            M_AXIS_TDATA  <= b1_data;
            M_AXIS_TSTRB  <= b1_strb;
            M_AXIS_TUSER  <= b1_user;
            M_AXIS_TLAST  <= b1_last;
            M_AXIS_TVALID <= 1'b1;
        end else if (M_AXIS_TREADY) begin
            M_AXIS_TVALID <= 1'b0;
        end
    end

    // Per-decision packet counters, wrapping naturally
    always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
        if (!AXI_RESETN) begin
            fwd_count      <= '0;
            bad_csum_count <= '0;
            ttl_exp_count  <= '0;
        end else begin
            if (inc_fwd) fwd_count      <= fwd_count + 32'd1;
            if (inc_bad) bad_csum_count <= bad_csum_count + 32'd1;
            if (inc_exp) ttl_exp_count  <= ttl_exp_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_ip_checksum_ttl_update.sv
// tb/tb_ip_checksum_ttl_update.sv - randomized scoreboard bench for ip_checksum_ttl_update
module tb_ip_checksum_ttl_update;

    localparam int SRC_POS = 16;
    localparam int DST_POS = 24;

    typedef struct packed {
        logic [255:0] d;
        logic [31:0]  s;
        logic [127:0] u;
        logic         l;
    } beat_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [255:0] s_tdata;
    logic [31:0]  s_tstrb;
    logic [127:0] s_tuser;
    logic         s_tvalid, s_tlast, s_tready;
    logic [255:0] m_tdata;
    logic [31:0]  m_tstrb;
    logic [127:0] m_tuser;
    logic         m_tvalid, m_tready, m_tlast;
    logic [31:0]  fwd, bad, expc;

    int    n_checks = 0;
    int    n_fail   = 0;
    beat_t in_q[$];
    beat_t exp_q[$];
    beat_t pkt_q[$];
    int    in_idx   = 0;
    bit    taken    = 1'b0;
    bit    chk_en   = 1'b0;
    int    m_fwd    = 0;
    int    m_bad    = 0;
    int    m_exp    = 0;
    logic [15:0] hw [10];

    ip_checksum_ttl_update dut (
        .AXI_ACLK(clk), .AXI_RESETN(rst_n),
        .S_AXIS_TDATA(s_tdata), .S_AXIS_TSTRB(s_tstrb), .S_AXIS_TUSER(s_tuser),
        .S_AXIS_TVALID(s_tvalid), .S_AXIS_TREADY(s_tready), .S_AXIS_TLAST(s_tlast),
        .M_AXIS_TDATA(m_tdata), .M_AXIS_TSTRB(m_tstrb), .M_AXIS_TUSER(m_tuser),
        .M_AXIS_TVALID(m_tvalid), .M_AXIS_TREADY(m_tready), .M_AXIS_TLAST(m_tlast),
        .fwd_count(fwd), .bad_csum_count(bad), .ttl_exp_count(expc)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] oc_add(input logic [15:0] a, input logic [15:0] b);
        int s;
        s = int'(a) + int'(b);
        if (s > 65535) s = s - 65535;
        return s[15:0];
    endfunction

    task automatic set_hdr(input logic [15:0] w4, input logic [15:0] w5);
        hw[0] = 16'h4500; hw[1] = 16'h0073; hw[2] = 16'h0000; hw[3] = 16'h4000;
        hw[4] = w4;       hw[5] = w5;       hw[6] = 16'hC0A8; hw[7] = 16'h0001;
        hw[8] = 16'hC0A8; hw[9] = 16'h00C7;
    endtask

    task automatic build_pkt(input logic [15:0] eth, input int len, input logic [7:0] src);
        pkt_q.delete();
        for (int k = 0; k < len; k++) begin
            beat_t b;
            b.d = {$urandom(), $urandom(), $urandom(), $urandom(),
                   $urandom(), $urandom(), $urandom(), $urandom()};
            b.s = $urandom();
            b.u = {$urandom(), $urandom(), $urandom(), $urandom()};
            b.u[SRC_POS +: 8] = src;
            b.l = (k == len - 1);
            if (k == 0) begin
                b.d[159:144] = eth;
                for (int i = 0; i < 9; i++) b.d[143-16*i -: 16] = hw[i];
            end
            if (k == 1) b.d[255:240] = hw[9];
            pkt_q.push_back(b);
        end
    endtask

    // Reference model: what the packet must look like on the output, if it appears at all
    task automatic commit_pkt();
        beat_t       b0;
        logic [15:0] acc;
        logic [7:0]  ttl;
        bit          cand;
        b0 = pkt_q[0];
        foreach (pkt_q[k]) in_q.push_back(pkt_q[k]);
        cand = (b0.d[159:144] == 16'h0800) && (b0.d[143:136] == 8'h45) && (pkt_q.size() > 1);
        if (!cand) begin
            foreach (pkt_q[k]) exp_q.push_back(pkt_q[k]);
        end else begin
            acc = 16'h0000;
            for (int i = 0; i < 9; i++) acc = oc_add(acc, b0.d[143-16*i -: 16]);
            acc = oc_add(acc, pkt_q[1].d[255:240]);
            if (acc != 16'hFFFF) begin
                m_bad++;
            end else begin
                ttl = b0.d[79:72];
                if (ttl >= 8'd2) begin
                    b0.d[79:72] = ttl - 8'd1;
                    b0.d[63:48] = oc_add(b0.d[63:48], 16'h0100);
                    m_fwd++;
                end else begin
                    b0.u[DST_POS +: 8] = b0.u[SRC_POS +: 8] << 1;
                    m_exp++;
                end
                exp_q.push_back(b0);
                for (int k = 1; k < pkt_q.size(); k++) exp_q.push_back(pkt_q[k]);
            end
        end
        pkt_q.delete();
    endtask

    task automatic build_rand();
        int          kind;
        int          len;
        logic [7:0]  src;
        logic [7:0]  ttl;
        logic [15:0] acc;
        kind = $urandom_range(0, 5);
        src  = 8'h01 << $urandom_range(0, 7);
        for (int i = 0; i < 10; i++) hw[i] = 16'($urandom());
        if (kind <= 3) begin
            len = $urandom_range(2, 4);
            hw[0][15:8] = 8'h45;
            case ($urandom_range(0, 3))
                0:       ttl = 8'd0;
                1:       ttl = 8'd1;
                2:       ttl = 8'd2;
                default: ttl = 8'($urandom());
            endcase
            hw[4][15:8] = ttl;
            hw[5] = 16'h0000;
            acc = 16'h0000;
            for (int i = 0; i < 10; i++) acc = oc_add(acc, hw[i]);
            hw[5] = ~acc;
            if (kind == 3) hw[5] = hw[5] ^ (16'h0001 << $urandom_range(0, 15));
            build_pkt(16'h0800, len, src);
        end else if (kind == 4) begin
            build_pkt(16'h0806, $urandom_range(1, 4), src);
        end else begin
            if ($urandom_range(0, 1) == 1) begin
                hw[0][15:8] = 8'h46;
                len = $urandom_range(1, 4);
            end else begin
                hw[0][15:8] = 8'h45;
                len = 1;
            end
            build_pkt(16'h0800, len, src);
        end
        commit_pkt();
    endtask

    task automatic drive(input beat_t b);
        s_tdata = b.d;
        s_tstrb = b.s;
        s_tuser = b.u;
        s_tlast = b.l;
    endtask

    task automatic run(input bit rnd, input int budget);
        int cyc = 0;
        while ((in_idx < in_q.size() || exp_q.size() != 0) && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (taken) begin
                s_tvalid = 1'b0;
                in_idx++;
                taken = 1'b0;
            end
            m_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (!s_tvalid && in_idx < in_q.size() && (!rnd || $urandom_range(0, 3) != 0)) begin
                drive(in_q[in_idx]);
                s_tvalid = 1'b1;
            end
            #1;
            taken = s_tvalid && s_tready;
        end
        if (cyc >= budget) begin
            n_checks++;
            n_fail++;
            $display("FAIL run_timeout: got %0d input beats and %0d outputs outstanding, required 0", in_q.size() - in_idx, exp_q.size());
            in_idx = in_q.size();
            exp_q.delete();
        end
        @(negedge clk);
        s_tvalid = 1'b0;
        if (taken) in_idx++;
        taken = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            s_tvalid = 1'b0;
            m_tready = 1'b1;
        end
    endtask

    // Output scoreboard and stall-stability checker
    initial begin
        bit           stall_prev = 1'b0;
        logic [255:0] stall_d    = '0;
        logic [255:0] stall_side = '0;
        beat_t        e;
        forever begin
            @(negedge clk);
            if (!chk_en) begin
                stall_prev = 1'b0;
            end else begin
                #2;
                if (stall_prev) begin
                    check("stall_valid", {255'd0, m_tvalid}, 256'd1);
                    check("stall_data", m_tdata, stall_d);
                    check("stall_side", {95'd0, m_tuser, m_tstrb, m_tlast}, stall_side);
                end
                if (m_tvalid && m_tready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL extra_beat: got output beat %h, required no beat", m_tdata);
                    end else begin
                        e = exp_q.pop_front();
                        check("beat_data", m_tdata, e.d);
                        check("beat_side", {95'd0, m_tuser, m_tstrb, m_tlast}, {95'd0, e.u, e.s, e.l});
                    end
                end
                stall_prev = m_tvalid && !m_tready;
                stall_d    = m_tdata;
                stall_side = {95'd0, m_tuser, m_tstrb, m_tlast};
            end
        end
    end

    initial begin
        int base;
        rst_n = 1'b0; s_tvalid = 1'b0; s_tdata = '0; s_tstrb = '0; s_tuser = '0;
        s_tlast = 1'b0; m_tready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_m_tvalid", {255'd0, m_tvalid}, 256'd0);
        check("rst_s_tready", {255'd0, s_tready}, 256'd0);
        check("rst_m_tdata", m_tdata, 256'd0);
        check("rst_counters", {160'd0, fwd, bad, expc}, 256'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("tready_before_edge", {255'd0, s_tready}, 256'd0);
        @(negedge clk);
        #1;
        check("tready_after_edge", {255'd0, s_tready}, 256'd1);
        chk_en = 1'b1;

        set_hdr(16'h4011, 16'hB861);
        build_pkt(16'h0800, 3, 8'h01);
        base = exp_q.size();
        commit_pkt();
        check("model_ttl", {248'd0, exp_q[base].d[79:72]}, 256'h3F);
        check("model_csum", {240'd0, exp_q[base].d[63:48]}, 256'hB961);

        set_hdr(16'h0111, 16'hF761);
        build_pkt(16'h0800, 3, 8'h04);
        base = exp_q.size();
        commit_pkt();
        check("model_cpu_port", {248'd0, exp_q[base].u[DST_POS +: 8]}, 256'h08);
        check("model_exp_data", exp_q[base].d, in_q[in_q.size() - 3].d);

        set_hdr(16'h4011, 16'hB862);
        build_pkt(16'h0800, 3, 8'h02);
        base = exp_q.size();
        commit_pkt();
        check("model_bad_drop", 256'(exp_q.size()), 256'(base));

        set_hdr(16'h4011, 16'hB861);
        build_pkt(16'h0800, 2, 8'h10);
        commit_pkt();
        build_pkt(16'h0806, 3, 8'h20);
        commit_pkt();
        build_pkt(16'h0800, 1, 8'h40);
        commit_pkt();
        run(1'b0, 400);
        idle(3);
        check("dir_fwd_count", {224'd0, fwd}, 256'd2);
        check("dir_bad_count", {224'd0, bad}, 256'd1);
        check("dir_exp_count", {224'd0, expc}, 256'd1);

        repeat (100) build_rand();
        run(1'b1, 8000);
        idle(3);
        check("rnd_fwd_count", {224'd0, fwd}, 256'(m_fwd));
        check("rnd_bad_count", {224'd0, bad}, 256'(m_bad));
        check("rnd_exp_count", {224'd0, expc}, 256'(m_exp));

        chk_en = 1'b0;
        set_hdr(16'h4011, 16'hB861);
        build_pkt(16'h0800, 3, 8'h01);
        m_tready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            drive(pkt_q[k]);
            s_tvalid = 1'b1;
            #1;
            check("emit_accept", {255'd0, s_tready}, 256'd1);
        end
        @(negedge clk);
        s_tvalid = 1'b0;
        #1;
        check("emit_valid", {255'd0, m_tvalid}, 256'd1);
        check("emit_no_ready", {255'd0, s_tready}, 256'd0);
        check("emit_ttl", {248'd0, m_tdata[79:72]}, 256'h3F);
        rst_n = 1'b0;
        #1;
        check("mid_rst_m_tvalid", {255'd0, m_tvalid}, 256'd0);
        check("mid_rst_m_out", {m_tdata[255:161] | 95'd0, m_tuser, m_tstrb, m_tlast}, 256'd0);
        check("mid_rst_m_tdata", m_tdata, 256'd0);
        check("mid_rst_s_tready", {255'd0, s_tready}, 256'd0);
        check("mid_rst_counters", {160'd0, fwd, bad, expc}, 256'd0);
        @(negedge clk);
        rst_n = 1'b1;
        pkt_q.delete();
        in_q.delete();
        exp_q.delete();
        in_idx = 0;
        taken = 1'b0;
        m_fwd = 0;
        m_bad = 0;
        m_exp = 0;
        @(negedge clk);
        #1;
        check("post_rst_tready", {255'd0, s_tready}, 256'd1);
        chk_en = 1'b1;
        set_hdr(16'h4011, 16'hB861);
        build_pkt(16'h0800, 3, 8'h01);
        commit_pkt();
        run(1'b1, 400);
        idle(3);
        check("post_rst_fwd", {224'd0, fwd}, 256'd1);
        check("post_rst_bad_exp", {192'd0, bad, expc}, 256'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ip_checksum_ttl_update.md
# ip_checksum_ttl_update

Stream stage directly downstream of the IPv4 header checksum partial-sum stage in the router output-port-lookup pipeline. For every IPv4 packet it:
- completes and verifies the 20-byte header checksum;
- decrements TTL and patches the checksum incrementally;
- redirects TTL-expired packets to the CPU port paired with the ingress port;
- drops packets with a bad checksum.

Non-IPv4 traffic passes through untouched.

## Interface
Parameters:
- C_M_AXIS_DATA_WIDTH, 256, master TDATA width (only 256 supported)
- C_S_AXIS_DATA_WIDTH, 256, slave TDATA width (only 256 supported)
- C_M_AXIS_TUSER_WIDTH, 128, master TUSER width
- C_S_AXIS_TUSER_WIDTH, 128, slave TUSER width
- SRC_PORT_POS, 16, LSB of 8-bit one-hot source-port field in TUSER
- DST_PORT_POS, 24, LSB of 8-bit one-hot destination-port field in TUSER

Ports:
- AXI_ACLK  in  1  clock; one clock domain
- AXI_RESETN  in  1  reset, asynchronous assert, active-low
- S_AXIS_TDATA  in  256  input data
- S_AXIS_TSTRB  in  32  input byte strobes
- S_AXIS_TUSER  in  128  input metadata
- S_AXIS_TVALID  in  1  input valid
- S_AXIS_TREADY  out  1  input ready
- S_AXIS_TLAST  in  1  input last beat
- M_AXIS_TDATA  out  256  output data
- M_AXIS_TSTRB  out  32  output strobes
- M_AXIS_TUSER  out  128  output metadata
- M_AXIS_TVALID  out  1  output valid
- M_AXIS_TREADY  in  1  output ready
- M_AXIS_TLAST  out  1  output last
- fwd_count  out  32  IPv4 packets forwarded with TTL decremented
- bad_csum_count  out  32  IPv4 packets dropped for bad checksum
- ttl_exp_count  out  32  IPv4 packets sent to CPU for TTL <= 1

## Operation
- Byte 0 of a beat is TDATA[255:248].
- Beat 0 field positions:
  - ethertype: [159:144]
  - IP header words: [143:128] ver/IHL/TOS, [127:112], [111:96], [95:80], [79:64] TTL/proto (TTL = [79:72]), [63:48] checksum, [47:32], [31:16], [15:0]
- Beat 1 [255:240] holds the last header word (dst IP low).
- IPv4 candidate: beat 0 with ethertype == 0x0800, [143:136] == 0x45, and TLAST == 0. Any other first beat goes to pass-through for the whole packet.
- Checksum verification:
  - Sum all ten 16-bit header words (checksum field included) in a 20-bit accumulator.
  - Fold carries twice (sum[15:0] + sum[19:16]).
  - Header is valid iff the folded result == 0xFFFF.
- Valid header, TTL >= 2:
  - TTL ← TTL − 1.
  - checksum ← HC + 0x0100 with end-around carry (one's complement add; carry out of bit 15 is added back at bit 0). Result 0xFFFF is emitted as-is.
  - fwd_count++.
- Valid header, TTL ∈ {0,1}:
  - Data is unchanged.
  - TUSER[DST_PORT_POS+:8] ← {TUSER[SRC_PORT_POS+:7], 1'b0}, i.e. the source port shifted left one bit, which is the paired CPU port.
  - ttl_exp_count++.
- Invalid header: the whole packet is dropped (no beat emitted) and bad_csum_count++.
- Counters wrap modulo 2^32 and update in the cycle the header decision is made.
- FSM states:
  - IDLE: awaiting beat 0.
    - Candidate → HDR_WAIT (beat 0 captured).
    - Non-candidate → PASS, or stays in IDLE if TLAST.
  - HDR_WAIT: awaiting beat 1.
    - Good → HDR_EMIT (beat 1 captured, decision made).
    - Bad → DROP, or IDLE if beat 1 has TLAST.
  - HDR_EMIT: present modified beat 0, then beat 1; S_AXIS_TREADY = 0.
    - After beat 1 is accepted downstream → PASS, or IDLE if beat 1 had TLAST.
  - PASS: registered pass-through; → IDLE on an accepted TLAST.
  - DROP: S_AXIS_TREADY = 1 and data discarded; → IDLE on TLAST.
- TSTRB and TLAST always travel with their data. TUSER is modified only on beat 0.

## Timing
- Reset values (asynchronous, immediate): all M_AXIS_* outputs 0, TVALID 0, S_AXIS_TREADY 0, counters 0, state IDLE.
  - S_AXIS_TREADY rises in the first clock edge after deassertion.
- Reset mid-packet: the partial packet is lost. After reset the block restarts in IDLE and treats the next input beat as beat 0.
- Handshake:
  - Transfer occurs on TVALID & TREADY at the rising edge.
  - M_AXIS_TVALID never drops and M_AXIS_TDATA/TUSER never change while TVALID=1 and TREADY=0.
- Latency and throughput:
  - Pass-through beats appear 1 cycle after acceptance.
  - IPv4 beat 0 appears 1 cycle after beat 1 is accepted.
  - One input bubble per IPv4 packet (HDR_EMIT).
  - Otherwise 1 beat/cycle when M_AXIS_TREADY=1.
- Backpressure: S_AXIS_TREADY = 0 whenever the output register holds an unaccepted beat. No data loss at any M_AXIS_TREADY pattern.
- Back-to-back packets: a TLAST beat and the next packet's beat 0 may be accepted in consecutive cycles.

## Test plan
- IPv4 header 4500 0073 0000 4000 4011 B861 C0A8 0001 C0A8 00C7, 3-beat packet → output TTL 0x3F, checksum 0xB961, fwd_count=1, beats bit-exact otherwise.
- Same header with TTL 0x01 and checksum 0xF761, src port 0x04 → data unchanged, TUSER dst = 0x08, ttl_exp_count=1.
- Same header with checksum 0xB862 → no output beats, bad_csum_count=1, next valid packet forwarded normally.
- ARP (ethertype 0x0806) and single-beat 0x0800 packet → bit-exact pass-through, all counters unchanged.
- Random M_AXIS_TREADY (50%) over 100 mixed packets → output equals the reference-model stream, no duplicate or lost beats, TVALID/TDATA stable under stall.
- AXI_RESETN pulsed low mid-packet in HDR_EMIT → outputs 0 immediately, next packet processed correctly, counters restart from 0.
